// File: rtl/shift_sequencer.sv
// Sequenced front-end around a 32-bit combinational shifter: one registered op at a time,
// valid/ready on both sides, two-pass rotates built from a left pass ORed with a right pass.

module shift_core (
   input  logic        n_rst,
   input  logic [31:0] a,
   input  logic [1:0]  sel,
   input  logic        arith,
   input  logic [4:0]  shft,
   output logic [31:0] out
);
   always_comb begin
      out = '0;
      if (n_rst) begin
         case (sel)
            2'd0: out = a << shft;
            2'd1: begin
               // kept as separate statements so >>> stays signed
               if (arith) out = $signed(a) >>> shft;
               else       out = a >> shft;
            end
            2'd2: out = {{24{a[7]}}, a[7:0]};
            default: out = {{16{a[15]}}, a[15:0]};
         endcase
      end
   end
endmodule

module shift_sequencer #(
   parameter bit ENABLE_ROTATE = 1'b1
) (
   input  logic        CLK,
   input  logic        N_RST,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [2:0]  OP,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] RESULT,
   output logic        ERR
);
   localparam logic [2:0] OP_SLL = 3'd0, OP_SRL = 3'd1, OP_SRA = 3'd2, OP_SEXT8 = 3'd3,
                          OP_SEXT16 = 3'd4, OP_ROL = 3'd5, OP_ROR = 3'd6;
   localparam logic [1:0] SEL_LEFT = 2'd0, SEL_RIGHT = 2'd1, SEL_SEXT8 = 2'd2, SEL_SEXT16 = 2'd3;

   typedef enum logic [1:0] {IDLE, EXEC, PASS2, DONE} state_e;

   state_e      state;
   logic [2:0]  op_q;
   logic [31:0] a_q, partial;
   logic [4:0]  n_q, rot_amt, sh_amt;
   logic [1:0]  sh_sel;
   logic        sh_arith, is_rot, illegal;
   logic [31:0] sh_out;
   logic        unused_b;

   assign unused_b = ^B[31:5];
   assign is_rot   = (op_q == OP_ROL) || (op_q == OP_ROR);
   assign illegal  = (op_q == 3'd7) || (is_rot && !ENABLE_ROTATE);
   // ROR n is ROL (32-n); 5-bit negate gives the mod-32 amount
   assign rot_amt  = (op_q == OP_ROL) ? n_q : 5'd0 - n_q;
   assign IN_READY = (state == IDLE) || (state == DONE && OUT_READY);

   always_comb begin
      sh_sel   = SEL_LEFT;
      sh_arith = 1'b0;
      sh_amt   = n_q;
      if (state == PASS2) begin
         sh_sel = SEL_RIGHT;
         sh_amt = 5'd0 - rot_amt;
      end else begin
         case (op_q)
            OP_SRL:    sh_sel = SEL_RIGHT;
            OP_SRA:    begin sh_sel = SEL_RIGHT; sh_arith = 1'b1; end
            OP_SEXT8:  begin sh_sel = SEL_SEXT8;  sh_amt = 5'd0; end
            OP_SEXT16: begin sh_sel = SEL_SEXT16; sh_amt = 5'd0; end
            OP_ROL, OP_ROR: sh_amt = rot_amt;
            default:   sh_sel = SEL_LEFT;
         endcase
      end
   end

   shift_core u_shift (
      .n_rst (N_RST),
      .a     (a_q),
      .sel   (sh_sel),
      .arith (sh_arith),
      .shft  (sh_amt),
      .out   (sh_out)
   );

   always_ff @(posedge CLK or negedge N_RST) begin
      if (!N_RST) begin
         state     <= IDLE;
         OUT_VALID <= 1'b0;
         RESULT    <= '0;
         ERR       <= 1'b0;
         op_q      <= '0;
         a_q       <= '0;
         n_q       <= '0;
         partial   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (IN_VALID) begin
                  op_q  <= OP;
                  a_q   <= A;
                  n_q   <= B[4:0];
                  state <= EXEC;
               end
            end
            EXEC: begin
               if (illegal) begin
                  RESULT    <= a_q;
                  ERR       <= 1'b1;
                  OUT_VALID <= 1'b1;
                  state     <= DONE;
               end else if (is_rot && rot_amt != 5'd0) begin
                  partial <= sh_out;
                  state   <= PASS2;
               end else begin
                  RESULT    <= is_rot ? a_q : sh_out;
                  ERR       <= 1'b0;
                  OUT_VALID <= 1'b1;
                  state     <= DONE;
               end
            end
            PASS2: begin
               RESULT    <= partial | sh_out;
               ERR       <= 1'b0;
               OUT_VALID <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (OUT_READY) begin
                  OUT_VALID <= 1'b0;
                  if (IN_VALID) begin
                     op_q  <= OP;
                     a_q   <= A;
                     n_q   <= B[4:0];
                     state <= EXEC;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
